aes_key_sched_ctrl: RTL and testbench
=====================================

// Module: aes_key_sched_ctrl
// PURPOSE
//  Iterative AES key-schedule sequencer and round-key server for 128/192/256-bit keys.
//  Replaces the unrolled, all-words-at-once expander with a controller:
//   - expands one 32-bit word per cycle into an internal 60x32 word store;
//   - the cipher round engine then fetches 128-bit round keys by index.
//  Sits between the key-load interface and the encrypt/decrypt round datapath.
// PARAMETERS
//  MAXW   60  word-store depth, 4*(14+1); fixed for AES-256 worst case
//  IDXW   4   round-index width (0..14)
// PORTS
//  clk        in   1    rising-edge clock
//  reset      in   1    asynchronous, active-high reset
//  key_in     in   256  cipher key, MSB-aligned (128-bit key in [255:128], 192-bit in [255:64])
//  key_size   in   2    0=128 (Nk4,Nr10), 1=192 (Nk6,Nr12), 2=256 (Nk8,Nr14), 3=illegal
//  start      in   1    1-cycle pulse; sampled only in IDLE or DONE
//  busy       out  1    high in LOAD/EXPAND
//  keys_ready out  1    high in DONE; round keys readable
//  cfg_err    out  1    sticky; set on start with key_size==3, cleared by next legal start
//  nr         out  4    round count of the current schedule (10/12/14); 0 after reset
//  rk_rd      in   1    round-key read strobe
//  rk_idx     in   4    round index 0..nr
//  rk_out     out  128  round key {w[4r],w[4r+1],w[4r+2],w[4r+3]}, w[4r] in [127:96]
//  rk_valid   out  1    1-cycle pulse, rk_out valid
// BEHAVIOUR
//  Reset values
//   - All outputs are 0. State is IDLE.
//   - Word store is not cleared; it is unreadable until the next DONE.
//  FSM: IDLE -> LOAD -> EXPAND -> DONE.
//   IDLE/DONE
//    - start with key_size==3: set cfg_err; state is unchanged.
//    - start with a legal key_size: latch Nk/Nr, clear cfg_err, drop keys_ready, go to LOAD.
//   LOAD (1 cycle)
//    - Write words 0..Nk-1 from key_in to the store and to an 8-word shift window.
//    - i = Nk, rcon = 8'h01, kmod = 0. Go to EXPAND.
//   EXPAND (one word per cycle)
//    - t = w[i-1]; p = w[i-Nk] (both taken from the window, no store reads).
//    - kmod==0: t = SubWord(RotWord(t)) ^ {rcon,24'h0}; then rcon = xtime(rcon).
//    - Nk==8 and kmod==4: t = SubWord(t).
//    - w[i] = p ^ t. Write w[i] to the store, shift the window, i++, kmod = (kmod+1) mod Nk.
//    - When i == 4*(Nr+1)-1 has been written, go to DONE.
//  Latency, start edge to keys_ready high
//   - 128-bit: 41 cycles. 192-bit: 47 cycles. 256-bit: 53 cycles (1 + 4*(Nr+1) - Nk).
//  start while busy: ignored; it does not restart and does not set cfg_err.
//  Round-key read
//   - rk_rd && keys_ready && rk_idx<=nr: rk_out/rk_valid registered 1 cycle after rk_rd.
//   - Back-to-back reads are allowed, one per cycle.
//   - Not ready or rk_idx>nr: rk_valid stays 0 and rk_out holds its last value.
//  start in DONE with a read in flight: the read completes with old data; keys_ready drops next cycle.
//  Reset mid-EXPAND: go to IDLE immediately; partially written words are discarded.
//  SubWord: 4 S-box lookups from the existing encrypt S-box module. rcon update is 8-bit xtime.
// TESTING
//  - 128 key 2b7e151628aed2a6abf7158809cf4f3c
//    -> keys_ready 41 cycles after start; rd idx1 = a0fafe1788542cb123a339392a6c7605;
//       idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
//  - 192 key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b
//    -> nr=12, ready at 47 cycles; idx12 = e98ba06f448c773c8ecc720401002202.
//  - 256 key 603deb10...0914dff4
//    -> nr=14, ready at 53 cycles; idx2 = 9ba354118e6925afa51a8b5f2067fcde;
//       idx14 = fe4890d1e6188d0b046df344706c631e.
//  - key_size=3 start
//    -> cfg_err=1, busy stays 0; a following legal start clears cfg_err.
//  - Reads with idx=11 under the 128-bit schedule, and reads while busy
//    -> no rk_valid. Back-to-back reads of idx 0,1,2 -> three consecutive rk_valid pulses.
//  - Reset asserted at cycle 20 of a 256 expansion
//    -> all outputs 0 asynchronously; a restart with the 128 key gives the correct idx10 key.

Source files
------------

// File: rtl/aes_key_sched_ctrl.sv
// ---------------------------------------------------------------------------
// aes_key_sched_ctrl
//   Iterative AES key-schedule sequencer and round-key server for 128, 192
//   and 256-bit keys. A start pulse loads the cipher key into a 60-word
//   store. The remaining schedule words are then expanded at one 32-bit word
//   per cycle. Once the schedule is complete, the round engine fetches
//   128-bit round keys by index.
//
// Ports
//   clk_i         rising-edge clock
//   reset_i       asynchronous active-high reset
//   key_in_i      cipher key, MSB-aligned (128: [255:128], 192: [255:64])
//   key_size_i    0=128, 1=192, 2=256, 3=illegal
//   start_i       1-cycle start pulse, honoured only when idle or done
//   busy_o        schedule is being loaded/expanded
//   keys_ready_o  schedule complete, round keys readable
//   cfg_err_o     sticky illegal-key-size flag, cleared by a legal start
//   nr_o          round count of the current schedule (10/12/14)
//   rk_rd_i       round-key read strobe
//   rk_idx_i      round index 0..nr
//   rk_out_o      round key {w[4r],w[4r+1],w[4r+2],w[4r+3]}
//   rk_valid_o    1-cycle pulse, rk_out_o carries a fresh round key
// ---------------------------------------------------------------------------
module aes_key_sched_ctrl #(
    parameter int MAXW = 60,
    parameter int IDXW = 4
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic [255:0]    key_in_i,
    input  logic [1:0]      key_size_i,
    input  logic            start_i,
    output logic            busy_o,
    output logic            keys_ready_o,
    output logic            cfg_err_o,
    output logic [IDXW-1:0] nr_o,
    input  logic            rk_rd_i,
    input  logic [IDXW-1:0] rk_idx_i,
    output logic [127:0]    rk_out_o,
    output logic            rk_valid_o
);

    localparam int AW = $clog2(MAXW);

    // Forward AES S-box.
    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_EXPAND = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[x];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    state_t            state_q;
    logic              busy_q;
    logic              keys_ready_q;
    logic              cfg_err_q;
    logic [IDXW-1:0]   nr_q;
    logic [3:0]        nk_q;
    logic [AW-1:0]     widx_q;
    logic [7:0]        rcon_q;
    logic [2:0]        kmod_q;
    logic [127:0]      rk_out_q;
    logic              rk_valid_q;

    // win_q[7] is always w[i-1]; w[i-Nk] sits at win_q[8-Nk].
    logic [31:0]       win_q   [0:7];
    logic [31:0]       store_q [0:MAXW-1];

    logic [31:0]       key_w_s    [0:7];
    logic [31:0]       win_load_s [0:7];
    logic [31:0]       prev_s;
    logic [31:0]       temp_s;
    logic [31:0]       word_d;
    logic [7:0]        rcon_d;
    logic [2:0]        kmod_d;
    logic              last_word_s;

    // Split the MSB-aligned key into words and right-align them in the window.
    always_comb begin
        for (int j = 0; j < 8; j++) begin
            key_w_s[j]    = key_in_i[255 - 32*j -: 32];
            win_load_s[j] = 32'h0000_0000;
        end
        case (nk_q)
            4'd4: for (int j = 0; j < 4; j++) win_load_s[j + 4] = key_w_s[j];
            4'd6: for (int j = 0; j < 6; j++) win_load_s[j + 2] = key_w_s[j];
            default: for (int j = 0; j < 8; j++) win_load_s[j] = key_w_s[j];
        endcase
    end

    // Next schedule word, rcon and key-word phase for the EXPAND step.
    always_comb begin
        case (nk_q)
            4'd4:    prev_s = win_q[4];
            4'd6:    prev_s = win_q[2];
            default: prev_s = win_q[0];
        endcase
        if (kmod_q == 3'd0) begin
            temp_s = sub_word({win_q[7][23:0], win_q[7][31:24]}) ^ {rcon_q, 24'h000000};
        end else if ((nk_q == 4'd8) && (kmod_q == 3'd4)) begin
            temp_s = sub_word(win_q[7]);
        end else begin
            temp_s = win_q[7];
        end
        word_d = prev_s ^ temp_s;
        if (kmod_q == 3'd0) begin
            rcon_d = xtime(rcon_q);
        end else begin
            rcon_d = rcon_q;
        end
        if ({1'b0, kmod_q} == (nk_q - 4'd1)) begin
            kmod_d = 3'd0;
        end else begin
            kmod_d = kmod_q + 3'd1;
        end
        last_word_s = (widx_q == {nr_q, 2'b11});
    end

    // Word store and shift window; no reset, contents only readable after DONE.
    always_ff @(posedge clk_i) begin
        if (state_q == ST_LOAD) begin
            // All eight key words are written; those beyond Nk are
            // overwritten by expansion before the store becomes readable.
            for (int j = 0; j < 8; j++) begin
                store_q[j] <= key_w_s[j];
                win_q[j]   <= win_load_s[j];
            end
        end else if (state_q == ST_EXPAND) begin
            store_q[widx_q] <= word_d;
            for (int j = 0; j < 7; j++) begin
                win_q[j] <= win_q[j + 1];
            end
            win_q[7] <= word_d;
        end
    end

    // Sequencer FSM with registered status and round-key read port.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            keys_ready_q <= 1'b0;
            cfg_err_q    <= 1'b0;
            nr_q         <= '0;
            nk_q         <= 4'd4;
            widx_q       <= '0;
            rcon_q       <= 8'h00;
            kmod_q       <= 3'd0;
            rk_out_q     <= 128'h0;
            rk_valid_q   <= 1'b0;
        end else begin
            // A read sampled on the same edge as a restart uses the old schedule.
            rk_valid_q <= 1'b0;
            if (rk_rd_i && keys_ready_q && (rk_idx_i <= nr_q)) begin
                rk_out_q   <= {store_q[{rk_idx_i, 2'b00}], store_q[{rk_idx_i, 2'b01}],
                               store_q[{rk_idx_i, 2'b10}], store_q[{rk_idx_i, 2'b11}]};
                rk_valid_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_i) begin
                        if (key_size_i == 2'd3) begin
                            cfg_err_q <= 1'b1;
                        end else begin
                            case (key_size_i)
                                2'd1:    begin nk_q <= 4'd6; nr_q <= IDXW'(12); end
                                2'd2:    begin nk_q <= 4'd8; nr_q <= IDXW'(14); end
                                default: begin nk_q <= 4'd4; nr_q <= IDXW'(10); end
                            endcase
                            cfg_err_q    <= 1'b0;
                            keys_ready_q <= 1'b0;
                            busy_q       <= 1'b1;
                            state_q      <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    widx_q  <= AW'(nk_q);
                    rcon_q  <= 8'h01;
                    kmod_q  <= 3'd0;
                    state_q <= ST_EXPAND;
                end
                ST_EXPAND: begin
                    widx_q <= widx_q + AW'(1);
                    rcon_q <= rcon_d;
                    kmod_q <= kmod_d;
                    if (last_word_s) begin
                        busy_q       <= 1'b0;
                        keys_ready_q <= 1'b1;
                        state_q      <= ST_DONE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy_o       = busy_q;
    assign keys_ready_o = keys_ready_q;
    assign cfg_err_o    = cfg_err_q;
    assign nr_o         = nr_q;
    assign rk_out_o     = rk_out_q;
    assign rk_valid_o   = rk_valid_q;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// ---------------------------------------------------------------------------
// tb_aes_key_sched_ctrl
//   Directed bench for aes_key_sched_ctrl. A cycle-level reference model
//   (FIPS-197 key expansion from a GF(2^8)-derived S-box, plus latency and
//   status rules) is compared against the DUT on every negative clock edge.
//   Directed steps add hand-computed round keys and latencies.
// ---------------------------------------------------------------------------
module tb_aes_key_sched_ctrl;

    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    logic         clk;
    logic         reset;
    logic [255:0] key_in;
    logic [1:0]   key_size;
    logic         start;
    logic         busy;
    logic         keys_ready;
    logic         cfg_err;
    logic [3:0]   nr;
    logic         rk_rd;
    logic [3:0]   rk_idx;
    logic [127:0] rk_out;
    logic         rk_valid;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int cyc_start;

    logic [7:0] tb_sbox [0:255];

    aes_key_sched_ctrl #(.MAXW(60), .IDXW(4)) dut (
        .clk_i(clk), .reset_i(reset), .key_in_i(key_in), .key_size_i(key_size),
        .start_i(start), .busy_o(busy), .keys_ready_o(keys_ready), .cfg_err_o(cfg_err),
        .nr_o(nr), .rk_rd_i(rk_rd), .rk_idx_i(rk_idx), .rk_out_o(rk_out), .rk_valid_o(rk_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference arithmetic ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int n = 0; n < 8; n++) begin
            if (b[n]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return 8'((b << n) | (b >> (8 - n)));
    endfunction

    function automatic logic [7:0] sbox_math(input logic [7:0] x);
        logic [7:0] inv = 8'h00;
        for (int y = 1; y < 256; y++) begin
            if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
        end
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {tb_sbox[w[31:24]], tb_sbox[w[23:16]], tb_sbox[w[15:8]], tb_sbox[w[7:0]]};
    endfunction

    function automatic logic [127:0] round_key(input logic [255:0] k, input logic [1:0] ks, input int r);
        logic [31:0] w [0:59];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        int nk = 4 + 2 * int'(ks);
        for (int i = 0; i < nk; i++) w[i] = k[255 - 32*i -: 32];
        for (int i = nk; i < 60; i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
                rc = gmul(rc, 8'h02);
            end else if (nk == 8 && i % nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    // ---------------- cycle-level model ----------------
    logic         m_busy, m_ready, m_err, m_valid;
    logic [3:0]   m_nr;
    logic [127:0] m_out;
    logic [255:0] m_key;
    logic [1:0]   m_ks;
    int           m_cnt;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy <= 1'b0; m_ready <= 1'b0; m_err <= 1'b0; m_valid <= 1'b0;
            m_nr <= 4'd0; m_out <= 128'h0; m_cnt <= 0;
        end else begin
            m_valid <= 1'b0;
            if (rk_rd && m_ready && rk_idx <= m_nr) begin
                m_valid <= 1'b1;
                m_out   <= round_key(m_key, m_ks, int'(rk_idx));
            end
            if (start && !m_busy) begin
                if (key_size == 2'd3) begin
                    m_err <= 1'b1;
                end else begin
                    m_err   <= 1'b0;
                    m_ready <= 1'b0;
                    m_busy  <= 1'b1;
                    m_key   <= key_in;
                    m_ks    <= key_size;
                    m_nr    <= 4'(10 + 2 * int'(key_size));
                    // start edge to ready: 1 + 4*(Nr+1) - Nk cycles
                    m_cnt   <= 1 + 4 * (11 + 2 * int'(key_size)) - (4 + 2 * int'(key_size));
                end
            end else if (m_busy) begin
                if (m_cnt == 1) begin
                    m_busy  <= 1'b0;
                    m_ready <= 1'b1;
                end
                m_cnt <= m_cnt - 1;
            end
        end
    end

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        check("cmp_busy",       128'(busy),       128'(m_busy));
        check("cmp_keys_ready", 128'(keys_ready), 128'(m_ready));
        check("cmp_cfg_err",    128'(cfg_err),    128'(m_err));
        check("cmp_nr",         128'(nr),         128'(m_nr));
        check("cmp_rk_valid",   128'(rk_valid),   128'(m_valid));
        check("cmp_rk_out",     rk_out,           m_out);
    end

    // ---------------- directed stimulus ----------------
    task automatic st_cycle(input logic [255:0] k, input logic [1:0] ks, input logic rd, input logic [3:0] idx);
        key_in = k; key_size = ks; start = 1'b1; rk_rd = rd; rk_idx = idx;
        @(posedge clk); #1;
        start = 1'b0; rk_rd = 1'b0;
        cyc_start = cyc;
    endtask

    task automatic rd_cycle(input logic [3:0] idx);
        rk_rd = 1'b1; rk_idx = idx;
        @(posedge clk); #1;
        rk_rd = 1'b0;
    endtask

    task automatic wait_ready(input string nm, input int lat);
        while (!keys_ready && (cyc - cyc_start) < 200) begin
            @(posedge clk); #1;
        end
        check(nm, 128'(cyc - cyc_start), 128'(lat));
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, "_busy"},  128'(busy), 128'h0);
        check({nm, "_ready"}, 128'(keys_ready), 128'h0);
        check({nm, "_err"},   128'(cfg_err), 128'h0);
        check({nm, "_nr"},    128'(nr), 128'h0);
        check({nm, "_valid"}, 128'(rk_valid), 128'h0);
        check({nm, "_rkout"}, rk_out, 128'h0);
    endtask

    logic [127:0] exp_b2b [0:2];

    initial begin
        reset = 1'b1; key_in = 256'h0; key_size = 2'd0; start = 1'b0; rk_rd = 1'b0; rk_idx = 4'd0;
        cyc_start = 0;
        for (int x = 0; x < 256; x++) tb_sbox[x] = sbox_math(8'(x));

        // pin the model with published vectors
        check("model_128_idx1",  round_key(K128, 2'd0, 1),  128'ha0fafe1788542cb123a339392a6c7605);
        check("model_128_idx10", round_key(K128, 2'd0, 10), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        check("model_192_idx12", round_key(K192, 2'd1, 12), 128'he98ba06f448c773c8ecc720401002202);
        check("model_256_idx2",  round_key(K256, 2'd2, 2),  128'h9ba354118e6925afa51a8b5f2067fcde);
        check("model_256_idx14", round_key(K256, 2'd2, 14), 128'hfe4890d1e6188d0b046df344706c631e);

        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;
        @(posedge clk); #1;

        // illegal size from IDLE
        st_cycle(K128, 2'd3, 1'b0, 4'd0);
        check("illegal_err", 128'(cfg_err), 128'h1);
        check("illegal_busy", 128'(busy), 128'h0);

        // 128-bit schedule; a read while busy must not respond
        st_cycle(K128, 2'd0, 1'b0, 4'd0);
        check("start128_err_clr", 128'(cfg_err), 128'h0);
        rd_cycle(4'd1);
        check("rd_busy_valid", 128'(rk_valid), 128'h0);
        wait_ready("lat128", 41);
        check("nr128", 128'(nr), 128'd10);
        rd_cycle(4'd1);
        check("rd128_1_valid", 128'(rk_valid), 128'h1);
        check("rd128_1", rk_out, 128'ha0fafe1788542cb123a339392a6c7605);
        rd_cycle(4'd10);
        check("rd128_10", rk_out, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        rd_cycle(4'd11);
        check("rd128_11_valid", 128'(rk_valid), 128'h0);
        check("rd128_11_hold", rk_out, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // back-to-back reads 0,1,2
        exp_b2b[0] = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        exp_b2b[1] = 128'ha0fafe1788542cb123a339392a6c7605;
        exp_b2b[2] = 128'hf2c295f27a96b9435935807a7359f67f;
        for (int n = 0; n < 3; n++) begin
            rk_rd = 1'b1; rk_idx = 4'(n);
            @(posedge clk); #1;
            check("b2b_valid", 128'(rk_valid), 128'h1);
            check("b2b_data", rk_out, exp_b2b[n]);
        end
        rk_rd = 1'b0;
        @(posedge clk); #1;

        // 192-bit schedule; illegal start while busy is ignored
        st_cycle(K192, 2'd1, 1'b0, 4'd0);
        repeat (3) @(posedge clk);
        #1;
        key_size = 2'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; key_size = 2'd1;
        check("busy_illegal_err", 128'(cfg_err), 128'h0);
        check("busy_illegal_busy", 128'(busy), 128'h1);
        wait_ready("lat192", 47);
        check("nr192", 128'(nr), 128'd12);
        rd_cycle(4'd12);
        check("rd192_12", rk_out, 128'he98ba06f448c773c8ecc720401002202);

        // illegal start in DONE keeps the schedule
        st_cycle(K192, 2'd3, 1'b0, 4'd0);
        check("done_illegal_err", 128'(cfg_err), 128'h1);
        check("done_illegal_ready", 128'(keys_ready), 128'h1);

        // restart with a read in flight: read returns old data
        st_cycle(K256, 2'd2, 1'b1, 4'd12);
        check("inflight_valid", 128'(rk_valid), 128'h1);
        check("inflight_data", rk_out, 128'he98ba06f448c773c8ecc720401002202);
        check("inflight_ready", 128'(keys_ready), 128'h0);
        check("inflight_err_clr", 128'(cfg_err), 128'h0);
        wait_ready("lat256", 53);
        check("nr256", 128'(nr), 128'd14);
        rd_cycle(4'd2);
        check("rd256_2", rk_out, 128'h9ba354118e6925afa51a8b5f2067fcde);
        rd_cycle(4'd14);
        check("rd256_14", rk_out, 128'hfe4890d1e6188d0b046df344706c631e);

        // reset in the middle of a 256-bit expansion
        st_cycle(K256, 2'd2, 1'b0, 4'd0);
        repeat (19) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check_all_zero("midreset");
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        st_cycle(K128, 2'd0, 1'b0, 4'd0);
        wait_ready("lat128_after_reset", 41);
        rd_cycle(4'd10);
        check("rd128_10_after_reset", rk_out, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        repeat (2) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
